// File: rtl/prio_sel_arb.sv
// prio_sel_arb: fixed-priority / round-robin selector with a one-word registered output stage
module prio_sel_arb #(
  parameter int N_CH = 4,
  parameter int DATA_W = 1,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic                   mode,
  output logic [DATA_W-1:0]      out_data,
  output logic [CH_W-1:0]        out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam logic [CH_W:0] NC = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST = CH_W'(N_CH-1);
  logic [CH_W-1:0] rr_ptr, g, idx;
  logic [CH_W:0] sum;
  logic any, load;
  assign any = |in_valid;
  assign load = !out_valid || out_ready;
  assign in_ready = (load && any && !rst) ? N_CH'(1) << g : '0;
  // scan from the furthest candidate down so the closest hit wins
  always_comb begin
    g = '0;
    idx = '0;
    sum = '0;
    for (int k = N_CH-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
      idx = mode ? CH_W'(sum >= NC ? sum - NC : sum) : CH_W'(k);
      if (in_valid[idx]) g = idx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= in_data[g*DATA_W +: DATA_W];
        out_ch <= g;
        rr_ptr <= g == LAST ? '0 : g + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_prio_sel_arb.sv
// tb_prio_sel_arb: directed + random scoreboard bench for prio_sel_arb (4 channels, 8-bit data)
module tb_prio_sel_arb;
  logic clk = 0, rst = 1, mode = 0, out_ready = 1;
  logic [31:0] in_data = '0;
  logic [3:0] in_valid = '0, in_ready;
  logic [7:0] out_data;
  logic [1:0] out_ch;
  logic out_valid;
  int tests = 0, fails = 0;
  logic m_valid = 0;
  logic [7:0] m_data = '0;
  int m_ch = 0, m_ptr = 0;
  logic [9:0] q[$];
  logic [9:0] e;

  prio_sel_arb #(.N_CH(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int grant(input logic [3:0] v, input logic m, input int p);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = m ? (p + k) % 4 : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // one cycle: drive, then at the falling edge check against the model and advance it
  task automatic cyc(input logic r, input logic m, input logic [3:0] v, input logic rdy, input logic [31:0] d);
    int gg;
    logic ld;
    rst = r; mode = m; in_valid = v; out_ready = rdy; in_data = d;
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_data", {24'd0, out_data}, {24'd0, m_data});
    chk("out_ch", {30'd0, out_ch}, m_ch);
    gg = grant(v, m, m_ptr);
    ld = !m_valid || rdy;
    chk("in_ready", {28'd0, in_ready}, (!r && ld && gg >= 0) ? 32'(1) << gg : 32'd0);
    if (r) begin
      m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0;
      q.delete();
    end else if (ld) begin
      m_valid = gg >= 0;
      if (gg >= 0) begin
        m_data = d[gg*8 +: 8];
        m_ch = gg;
        m_ptr = (gg + 1) % 4;
        q.push_back({2'(gg), m_data});
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_word: got %0h with empty scoreboard", {out_ch, out_data});
      end else begin
        e = q.pop_front();
        chk("mon_word", {22'd0, out_ch, out_data}, {22'd0, e});
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 0, 0, 1, $urandom());
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_ch", {30'd0, out_ch}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    repeat (3) cyc(0, 0, 4'hF, 1, 32'hD3C2B1A0);
    chk("fixed_data", {24'd0, out_data}, 32'hA0);
    chk("fixed_ch", {30'd0, out_ch}, 0);
    cyc(1, 1, 0, 1, $urandom());
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 4'hF, 1, $urandom());
      chk("rr_seq", {30'd0, out_ch}, i % 4);
      chk("rr_valid", {31'd0, out_valid}, 1);
    end
    cyc(0, 1, 4'b0100, 1, $urandom());
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 4'b0101, 1, $urandom());
      chk("rr_skip", {30'd0, out_ch}, (i % 2) * 2);
    end
    cyc(0, 0, 0, 1, $urandom());
    cyc(0, 0, 4'b0010, 0, $urandom());
    repeat (3) cyc(0, 0, 4'b0010, 0, $urandom());
    cyc(0, 0, 4'b0010, 1, $urandom());
    chk("bp_ch", {30'd0, out_ch}, 1);
    cyc(0, 0, 0, 1, $urandom());
    chk("drain_valid", {31'd0, out_valid}, 0);
    chk("drain_ch", {30'd0, out_ch}, 1);
    cyc(0, 0, 4'b0010, 1, $urandom());
    cyc(0, 0, 4'b0010, 0, $urandom());
    cyc(1, 0, 4'b0010, 0, $urandom());
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_ch", {30'd0, out_ch}, 0);
    cyc(0, 1, 4'b1000, 1, $urandom());
    chk("post_rst_ch", {30'd0, out_ch}, 3);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
          $urandom_range(0, 9) < 7, $urandom());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prio_sel_arb.md
PRIO_SEL_ARB -- requirements
Module: prio_sel_arb

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of input channels (legal range 2..16).
REQ-002 The block SHALL have parameter DATA_W, default 1, giving the data width per channel (legal range 1..64).
REQ-003 The block SHALL have derived localparam CH_W = $clog2(N_CH), giving the channel index width.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_data, input, width N_CH*DATA_W: channel i data is in_data[i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port in_valid, input, width N_CH: per-channel request.
REQ-008 The block SHALL have port in_ready, output, width N_CH: per-channel accept, combinational, one-hot or zero.
REQ-009 The block SHALL have port mode, input, width 1: 0 = fixed priority, 1 = round-robin.
REQ-010 The block SHALL have port out_data, output, width DATA_W: registered selected data.
REQ-011 The block SHALL have port out_ch, output, width CH_W: registered index of the granted channel.
REQ-012 The block SHALL have port out_valid, output, width 1: out_data and out_ch hold a word.
REQ-013 The block SHALL have port out_ready, input, width 1: downstream accept.

Function
REQ-014 The block SHALL define load = !out_valid || out_ready; a transfer from channel g occurs in a cycle where load && in_valid[g] && g is the grant.
REQ-015 The block SHALL, in fixed-priority mode (mode=0), grant the lowest-index asserted in_valid bit; channel 0 has highest priority.
REQ-016 The block SHALL, in round-robin mode (mode=1), grant the first asserted in_valid bit searching upward from rr_ptr with wrap-around from N_CH-1 to 0.
REQ-017 The block SHALL update rr_ptr to (g+1) mod N_CH after every transfer in either mode; rr_ptr SHALL NOT change in cycles without a transfer.
REQ-018 The block SHALL assert in_ready[g] only for the granted channel and only when load=1; all other in_ready bits SHALL be 0.
REQ-019 The block SHALL, on a transfer, register out_data = data of channel g, out_ch = g and out_valid = 1 at the next edge; latency is 1 cycle.
REQ-020 The block SHALL sustain 1 word per cycle while out_ready=1 and any in_valid is set.
REQ-021 The block SHALL hold out_data, out_ch and out_valid stable while out_valid=1 && out_ready=0, with in_ready all 0.
REQ-022 The block SHALL clear out_valid at the next edge when load=1 and no in_valid bit is set; out_data and out_ch SHALL retain their last values.
REQ-023 The block SHALL take a mode change effect in the same cycle, without resetting rr_ptr.
REQ-024 The block SHALL raise no in_ready bit when in_valid is all zero.
REQ-025 The block SHALL allow in_valid to change while not granted; no request latching occurs.

Reset
REQ-026 The block SHALL, while rst=1 at a clock edge, set out_valid=0, out_data=0, out_ch=0 and rr_ptr=0.
REQ-027 The block SHALL force in_ready to all zero while rst=1.
REQ-028 The block SHALL, on rst asserted mid-operation, discard any held output word; no transfer occurs in the reset cycle.
REQ-029 The block SHALL, after rst deasserts, resume arbitration in the first cycle with rr_ptr=0.

Verification
REQ-030 The bench SHALL cover fixed priority (N_CH=4, DATA_W=8): mode=0, in_valid=4'b1111, data A0/B1/C2/D3, out_ready=1 -> in_ready=4'b0001 every cycle; out_data=A0, out_ch=0 one cycle later.
REQ-031 The bench SHALL cover round-robin: mode=1, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles; out_valid stays 1.
REQ-032 The bench SHALL cover round-robin wrap and skip: mode=1, rr_ptr=3, in_valid=4'b0101 -> grant 0, then 2, then 0.
REQ-033 The bench SHALL cover backpressure: out_valid=1 and out_ready=0 for 3 cycles with in_valid=4'b0010 -> in_ready=0 and out_data/out_ch unchanged; the first cycle with out_ready=1 -> in_ready=4'b0010 and a new word next cycle.
REQ-034 The bench SHALL cover drain: in_valid=0 and out_ready=1 with out_valid=1 -> out_valid=0 next cycle, out_data retained.
REQ-035 The bench SHALL cover reset mid-hold: rst=1 for one cycle while out_valid=1, out_ready=0 -> out_valid=0, out_ch=0, in_ready=0; after release with mode=1, in_valid=4'b1000 -> grant 3.
